// File: rtl/i2c_arbiter.sv
// Round-robin arbiter for two clients of one I2C master: each grant becomes a single-byte
// transaction, with a watchdog on both the ena/busy handshake and the busy period.
module i2c_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 4095
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [6:0] req0_addr,
  input  logic       req0_rw,
  input  logic [7:0] req0_wdata,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [6:0] req1_addr,
  input  logic       req1_rw,
  input  logic [7:0] req1_wdata,
  output logic       req1_ready,
  output logic       done0,
  output logic       done1,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       rsp_timeout,
  output logic       i2c_ena,
  output logic [6:0] i2c_addr,
  output logic       i2c_rw,
  output logic [7:0] i2c_data_wr,
  input  logic       i2c_busy,
  input  logic [7:0] i2c_data_rd,
  input  logic       i2c_ack_error
);
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned WDOG_W = 12;
  localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_grant_q, last_grant_d;
  logic [WDOG_W-1:0]   wdog_q, wdog_d, wdog_inc;
  logic [DATA_W-1:0]   cap_rdata_q, cap_rdata_d;
  logic                cap_load_q, cap_load_d;
  logic                cap_err_q, cap_err_d;
  logic                cap_to_q, cap_to_d;
  logic                ena_d, rw_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   wdata_d, rdata_d;
  logic                done0_d, done1_d, err_d, to_d;
  logic                grant0, grant1;

  // req0 wins when alone or when req1 was served last; the two grants never overlap
  assign grant0     = req0_valid && (!req1_valid || last_grant_q);
  assign grant1     = req1_valid && (!req0_valid || !last_grant_q);
  assign req0_ready = !reset && (state_q == S_IDLE) && grant0;
  assign req1_ready = !reset && (state_q == S_IDLE) && grant1;
  assign wdog_inc   = wdog_q + WDOG_W'(1);

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    wdog_d       = wdog_q;
    cap_rdata_d  = cap_rdata_q;
    cap_load_d   = cap_load_q;
    cap_err_d    = cap_err_q;
    cap_to_d     = cap_to_q;
    ena_d        = i2c_ena;
    addr_d       = i2c_addr;
    rw_d         = i2c_rw;
    wdata_d      = i2c_data_wr;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
    rdata_d      = rsp_rdata;
    err_d        = rsp_err;
    to_d         = rsp_timeout;
    case (state_q)
      S_IDLE: begin
        if (grant0 || grant1) begin
          owner_d = grant1;
          addr_d  = grant1 ? req1_addr : req0_addr;
          rw_d    = grant1 ? req1_rw : req0_rw;
          wdata_d = grant1 ? req1_wdata : req0_wdata;
          ena_d   = 1'b1;
          wdog_d  = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // busy sampled on the limit cycle still counts as a start
        if (i2c_busy) begin
          ena_d   = 1'b0;
          wdog_d  = '0;
          state_d = S_WAIT;
        end else if (wdog_inc == WDOG_LIMIT) begin
          ena_d      = 1'b0;
          cap_load_d = 1'b0;
          cap_err_d  = 1'b1;
          cap_to_d   = 1'b1;
          state_d    = S_DONE;
        end else begin
          wdog_d = wdog_inc;
        end
      end
      S_WAIT: begin
        ena_d = 1'b0;
        if (!i2c_busy) begin
          cap_rdata_d = i2c_data_rd;
          cap_load_d  = i2c_rw;
          cap_err_d   = i2c_ack_error;
          cap_to_d    = 1'b0;
          state_d     = S_DONE;
        end else if (wdog_inc == WDOG_LIMIT) begin
          cap_load_d = 1'b0;
          cap_err_d  = 1'b1;
          cap_to_d   = 1'b1;
          state_d    = S_DONE;
        end else begin
          wdog_d = wdog_inc;
        end
      end
      S_DONE: begin
        if (cap_load_q) rdata_d = cap_rdata_q;
        err_d        = cap_err_q;
        to_d         = cap_to_q;
        done0_d      = !owner_q;
        done1_d      = owner_q;
        last_grant_d = owner_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      wdog_q       <= '0;
      cap_rdata_q  <= '0;
      cap_load_q   <= 1'b0;
      cap_err_q    <= 1'b0;
      cap_to_q     <= 1'b0;
      i2c_ena      <= 1'b0;
      i2c_addr     <= '0;
      i2c_rw       <= 1'b0;
      i2c_data_wr  <= '0;
      done0        <= 1'b0;
      done1        <= 1'b0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
      rsp_timeout  <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      wdog_q       <= wdog_d;
      cap_rdata_q  <= cap_rdata_d;
      cap_load_q   <= cap_load_d;
      cap_err_q    <= cap_err_d;
      cap_to_q     <= cap_to_d;
      i2c_ena      <= ena_d;
      i2c_addr     <= addr_d;
      i2c_rw       <= rw_d;
      i2c_data_wr  <= wdata_d;
      done0        <= done0_d;
      done1        <= done1_d;
      rsp_rdata    <= rdata_d;
      rsp_err      <= err_d;
      rsp_timeout  <= to_d;
    end
  end

endmodule
